// File: rtl/gb_stream_ctrl.sv
// Raster sequencing controller for the Gaussian-blur stencil datapath.
// Define GB_CTRL_BORDER_EN to emit border pixels as flagged pass-through beats.
module gb_stream_ctrl #(
  parameter int unsigned IMG_W = 488,
  parameter int unsigned IMG_H = 648,
  parameter int unsigned WIN   = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       step,
  input  logic       start,
  input  logic       in_tvalid,
  output logic       in_tready,
  output logic       lb_wr_en,
  output logic [2:0] lb_wr_row,
  output logic [8:0] lb_addr,
  output logic [9:0] row_idx,
  output logic       win_shift,
  output logic       out_load,
  output logic       out_tvalid,
  input  logic       out_tready,
  output logic       out_border,
  output logic       busy,
  output logic       frame_done
);

  localparam int unsigned XW = 9;
  localparam int unsigned YW = 10;
  localparam int unsigned WW = 3;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_e;

  state_e        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [WW-1:0] w_q, w_d;
  logic          out_tvalid_q, out_tvalid_d;
  logic          out_border_q, out_border_d;

  logic acc, pop, last_col, last_row, interior;

  // Handshake and datapath strobes; all collapse to 0 when step is low.
  always_comb begin
    in_tready = step & (state_q == RUN) & (~out_tvalid_q | out_tready);
    acc       = in_tready & in_tvalid;
    pop       = step & out_tvalid_q & out_tready;
    last_col  = (x_q == XW'(IMG_W - 1));
    last_row  = (y_q == YW'(IMG_H - 1));
    interior  = (x_q >= XW'(WIN - 1)) & (y_q >= YW'(WIN - 1));
`ifdef GB_CTRL_BORDER_EN
    out_load  = acc;
`else
    out_load  = acc & interior;
`endif
  end

  // Next-state: frame sequencing, raster counters and the one-entry output register.
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    w_d          = w_q;
    out_tvalid_d = out_tvalid_q;
    out_border_d = out_border_q;

    if (out_load) begin
      out_tvalid_d = 1'b1;
`ifdef GB_CTRL_BORDER_EN
      out_border_d = ~interior;
`endif
    end else if (pop) begin
      out_tvalid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        x_d = '0;
        y_d = '0;
        w_d = '0;
        if (step && start) state_d = RUN;
      end
      RUN: begin
        if (acc) begin
          if (last_col) begin
            x_d = '0;
            if (last_row) begin
              y_d     = '0;
              w_d     = '0;
              state_d = FLUSH;
            end else begin
              y_d = y_q + YW'(1);
              w_d = w_q + WW'(1);
            end
          end else begin
            x_d = x_q + XW'(1);
          end
        end
      end
      FLUSH: begin
        if (step && (!out_tvalid_q || out_tready)) state_d = DONE;
      end
      DONE: begin
        if (step) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      w_q          <= '0;
      out_tvalid_q <= 1'b0;
      out_border_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      w_q          <= w_d;
      out_tvalid_q <= out_tvalid_d;
      out_border_q <= out_border_d;
    end
  end

  assign lb_wr_en   = acc;
  assign win_shift  = acc;
  assign lb_wr_row  = w_q;
  assign lb_addr    = x_q;
  assign row_idx    = y_q;
  assign out_tvalid = out_tvalid_q;
  assign out_border = out_border_q;
  assign busy       = (state_q != IDLE);
  assign frame_done = (state_q == DONE);

endmodule

// File: tb/tb_gb_stream_ctrl.sv
// Randomized bench for gb_stream_ctrl on a reduced image, checked against a
// count-based model of the raster/handshake rules.
module tb_gb_stream_ctrl;

  localparam int W     = 20;
  localparam int H     = 14;
  localparam int WIN   = 9;
  localparam int N_ACC = W * H;
`ifdef GB_CTRL_BORDER_EN
  localparam int N_OUT = W * H;
  localparam int FIRST = 0;
`else
  localparam int N_OUT = (W - WIN + 1) * (H - WIN + 1);
  localparam int FIRST = WIN - 1;
`endif

  logic       clk = 1'b0;
  logic       rst, step, start, in_tvalid, out_tready;
  logic       in_tready, lb_wr_en, win_shift, out_load, out_tvalid;
  logic       out_border, busy, frame_done;
  logic [2:0] lb_wr_row;
  logic [8:0] lb_addr;
  logic [9:0] row_idx;

  gb_stream_ctrl #(.IMG_W(W), .IMG_H(H), .WIN(WIN)) dut (
    .clk(clk), .rst(rst), .step(step), .start(start),
    .in_tvalid(in_tvalid), .in_tready(in_tready),
    .lb_wr_en(lb_wr_en), .lb_wr_row(lb_wr_row), .lb_addr(lb_addr),
    .row_idx(row_idx), .win_shift(win_shift), .out_load(out_load),
    .out_tvalid(out_tvalid), .out_tready(out_tready), .out_border(out_border),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: frame phase flags, accept index within the frame, entries held in the output register.
  bit m_run = 0, m_flush = 0, m_done = 0, m_border = 0;
  int m_k = 0, m_pend = 0;
  int n_acc = 0, n_beats = 0, n_frames = 0, cyc = 0;
  int first_acc_cyc = -1, first_tv_cyc = -1, row8_wrrow = -1;

  logic [4:0] trace_a[$];
  logic [4:0] trace_b[$];

  always @(negedge clk) begin : mon
    int ex, ey;
    bit rdy, acc, ld, bord, popped;
    ex   = m_k % W;
    ey   = m_k / W;
    rdy  = step && m_run && (m_pend == 0 || out_tready);
    acc  = rdy && in_tvalid;
    bord = (ex < WIN - 1) || (ey < WIN - 1);
`ifdef GB_CTRL_BORDER_EN
    ld = acc;
`else
    ld = acc && !bord;
`endif
    n_checks++;
    if (in_tready !== rdy) begin n_errors++; $display("FAIL in_tready cyc=%0d got=%b exp=%b", cyc, in_tready, rdy); end
    n_checks++;
    if (lb_wr_en !== acc || win_shift !== acc) begin n_errors++; $display("FAIL wr_en/shift cyc=%0d got=%b/%b exp=%b", cyc, lb_wr_en, win_shift, acc); end
    n_checks++;
    if (out_load !== ld) begin n_errors++; $display("FAIL out_load cyc=%0d got=%b exp=%b", cyc, out_load, ld); end
    n_checks++;
    if (out_tvalid !== (m_pend > 0)) begin n_errors++; $display("FAIL out_tvalid cyc=%0d got=%b exp=%b", cyc, out_tvalid, m_pend > 0); end
    n_checks++;
    if (busy !== (m_run || m_flush || m_done)) begin n_errors++; $display("FAIL busy cyc=%0d got=%b", cyc, busy); end
    n_checks++;
    if (frame_done !== m_done) begin n_errors++; $display("FAIL frame_done cyc=%0d got=%b exp=%b", cyc, frame_done, m_done); end
    if (acc) begin
      n_checks++;
      if (lb_addr !== 9'(ex) || row_idx !== 10'(ey) || lb_wr_row !== 3'(ey % 8)) begin
        n_errors++;
        $display("FAIL address cyc=%0d got x=%0d y=%0d w=%0d exp x=%0d y=%0d w=%0d",
                 cyc, lb_addr, row_idx, lb_wr_row, ex, ey, ey % 8);
      end
    end
`ifdef GB_CTRL_BORDER_EN
    if (m_pend > 0) begin
      n_checks++;
      if (out_border !== m_border) begin n_errors++; $display("FAIL out_border cyc=%0d got=%b exp=%b", cyc, out_border, m_border); end
    end
`else
    n_checks++;
    if (out_border !== 1'b0) begin n_errors++; $display("FAIL out_border_tied cyc=%0d got=%b exp=0", cyc, out_border); end
`endif
    if (acc && ex == FIRST && ey == FIRST) first_acc_cyc = cyc;
    if (out_tvalid === 1'b1 && first_tv_cyc < 0) first_tv_cyc = cyc;
    if (acc && ex == 0 && ey == 8) row8_wrrow = int'(lb_wr_row);

    if (rst) begin
      m_run = 0; m_flush = 0; m_done = 0; m_k = 0; m_pend = 0; m_border = 0;
    end else if (step) begin
      popped = (m_pend > 0) && out_tready;
      if (popped) n_beats++;
      if (acc) n_acc++;
      if (m_done) begin
        m_done = 0;
        n_frames++;
      end else if (m_flush) begin
        if (m_pend == 0 || popped) begin m_flush = 0; m_done = 1; end
      end else if (m_run) begin
        if (acc) begin
          m_k++;
          if (m_k == N_ACC) begin m_run = 0; m_flush = 1; m_k = 0; end
        end
      end else if (start) begin
        m_run = 1;
        m_k   = 0;
      end
      m_pend = m_pend - int'(popped) + int'(ld);
      if (ld) m_border = bord;
    end
    cyc++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; step = 1; start = 0; in_tvalid = 1; out_tready = 1;
    tick(3);
    n_checks++;
    if (in_tready !== 0 || out_tvalid !== 0 || busy !== 0 || frame_done !== 0 ||
        lb_wr_en !== 0 || win_shift !== 0 || out_load !== 0 || out_border !== 0) begin
      n_errors++;
      $display("FAIL reset_outputs rdy=%b tv=%b busy=%b done=%b exp all 0", in_tready, out_tvalid, busy, frame_done);
    end
    n_checks++;
    if (lb_addr !== 0 || row_idx !== 0 || lb_wr_row !== 0) begin
      n_errors++;
      $display("FAIL reset_counters x=%0d y=%0d w=%0d exp 0", lb_addr, row_idx, lb_wr_row);
    end
    rst = 0;
    tick(3);
    n_checks++;
    if (busy !== 0 || in_tready !== 0) begin n_errors++; $display("FAIL idle_hold busy=%b rdy=%b exp 0", busy, in_tready); end
  endtask

  task automatic test_full_frame();
    int a0, b0, f0;
    a0 = n_acc; b0 = n_beats; f0 = n_frames;
    first_acc_cyc = -1; first_tv_cyc = -1; row8_wrrow = -1;
    step = 1; in_tvalid = 1; out_tready = 1; start = 1;
    tick(1);
    start = 0;
    for (int i = 0; i < N_ACC * 4 && n_frames == f0; i++) tick(1);
    n_checks++;
    if (n_frames - f0 != 1) begin n_errors++; $display("FAIL full_frame_done got=%0d exp=1", n_frames - f0); end
    n_checks++;
    if (n_acc - a0 != N_ACC) begin n_errors++; $display("FAIL full_frame_accepts got=%0d exp=%0d", n_acc - a0, N_ACC); end
    n_checks++;
    if (n_beats - b0 != N_OUT) begin n_errors++; $display("FAIL full_frame_beats got=%0d exp=%0d", n_beats - b0, N_OUT); end
    n_checks++;
    if (first_acc_cyc < 0 || first_tv_cyc != first_acc_cyc + 1) begin
      n_errors++;
      $display("FAIL first_beat_latency got=%0d exp=%0d", first_tv_cyc, first_acc_cyc + 1);
    end
    n_checks++;
    if (row8_wrrow != 0) begin n_errors++; $display("FAIL ring_wrap row8 got=%0d exp=0", row8_wrrow); end
    tick(4);
    n_checks++;
    if (n_frames - f0 != 1 || busy !== 0) begin n_errors++; $display("FAIL single_done frames=%0d busy=%b exp 1/0", n_frames - f0, busy); end
  endtask

  task automatic test_backpressure();
    int a0, b0, f0;
    logic [8:0] sx;
    logic [9:0] sy;
    a0 = n_acc; b0 = n_beats; f0 = n_frames;
    step = 1; in_tvalid = 1; out_tready = 1; start = 1;
    tick(1);
    start = 0;
    for (int i = 0; i < N_ACC && !(out_tvalid === 1'b1 && row_idx == 10); i++) tick(1);
    out_tready = 0;
    sx = lb_addr; sy = row_idx;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++;
      if (in_tready !== 0 || out_tvalid !== 1 || lb_addr !== sx || row_idx !== sy) begin
        n_errors++;
        $display("FAIL backpressure i=%0d rdy=%b tv=%b x=%0d y=%0d exp 0/1/%0d/%0d", i, in_tready, out_tvalid, lb_addr, row_idx, sx, sy);
      end
      tick(1);
    end
    out_tready = 1;
    for (int i = 0; i < N_ACC * 4 && n_frames == f0; i++) tick(1);
    n_checks++;
    if (n_acc - a0 != N_ACC || n_beats - b0 != N_OUT || n_frames - f0 != 1) begin
      n_errors++;
      $display("FAIL backpressure_counts acc=%0d beats=%0d frames=%0d exp %0d/%0d/1", n_acc - a0, n_beats - b0, n_frames - f0, N_ACC, N_OUT);
    end
  endtask

  task automatic run_trace(input bit toggle);
    int f0;
    f0 = n_frames;
    in_tvalid = 1; out_tready = 1; start = 1;
    for (int i = 0; i < N_ACC * 6 && n_frames == f0; i++) begin
      step = toggle ? (i % 2 == 0) : 1'b1;
      if (i > 0) start = 0;
      #1;
      if (step) begin
        if (toggle) trace_b.push_back({in_tready, out_load, out_tvalid, busy, frame_done});
        else        trace_a.push_back({in_tready, out_load, out_tvalid, busy, frame_done});
      end
      tick(1);
    end
    step = 1; start = 0;
    n_checks++;
    if (n_frames - f0 != 1) begin n_errors++; $display("FAIL trace_frame toggle=%0d frames=%0d exp=1", toggle, n_frames - f0); end
  endtask

  task automatic test_step_toggle();
    int bad;
    trace_a.delete();
    trace_b.delete();
    run_trace(1'b0);
    run_trace(1'b1);
    n_checks++;
    if (trace_a.size() != trace_b.size()) begin
      n_errors++;
      $display("FAIL step_toggle_len got=%0d exp=%0d", trace_b.size(), trace_a.size());
    end
    bad = -1;
    for (int i = 0; i < trace_a.size() && i < trace_b.size(); i++)
      if (bad < 0 && trace_a[i] !== trace_b[i]) bad = i;
    n_checks++;
    if (bad >= 0) begin
      n_errors++;
      $display("FAIL step_toggle_seq idx=%0d got=%b exp=%b", bad, trace_b[bad], trace_a[bad]);
    end
  endtask

  task automatic test_mid_reset();
    int f0;
    f0 = n_frames;
    step = 1; in_tvalid = 1; out_tready = 1; start = 1;
    tick(1);
    start = 0;
    for (int i = 0; i < N_ACC && !(lb_addr == 10 && row_idx == 10); i++) tick(1);
    n_checks++;
    if (out_tvalid !== 1'b1 || busy !== 1'b1) begin n_errors++; $display("FAIL mid_reset_pre tv=%b busy=%b exp 1/1", out_tvalid, busy); end
    rst = 1;
    tick(1);
    rst = 0;
    n_checks++;
    if (busy !== 0 || out_tvalid !== 0 || lb_addr !== 0 || row_idx !== 0 || lb_wr_row !== 0 || frame_done !== 0) begin
      n_errors++;
      $display("FAIL mid_reset_post busy=%b tv=%b x=%0d y=%0d w=%0d done=%b exp all 0", busy, out_tvalid, lb_addr, row_idx, lb_wr_row, frame_done);
    end
    tick(5);
    n_checks++;
    if (n_frames != f0) begin n_errors++; $display("FAIL mid_reset_nodone frames=%0d exp=%0d", n_frames, f0); end
    test_full_frame();
  endtask

  task automatic test_random();
    int f0, a0, b0;
    f0 = n_frames; a0 = n_acc; b0 = n_beats;
    for (int i = 0; i < 20000 && n_frames < f0 + 2; i++) begin
      step       = ($urandom_range(0, 3) != 0);
      in_tvalid  = ($urandom_range(0, 9) < 7);
      out_tready = ($urandom_range(0, 9) < 6);
      start      = ($urandom_range(0, 3) == 0);
      tick(1);
    end
    step = 1; start = 0; out_tready = 1;
    n_checks++;
    if (n_frames - f0 != 2 || n_acc - a0 != 2 * N_ACC || n_beats - b0 != 2 * N_OUT) begin
      n_errors++;
      $display("FAIL random_frames frames=%0d acc=%0d beats=%0d exp 2/%0d/%0d", n_frames - f0, n_acc - a0, n_beats - b0, 2 * N_ACC, 2 * N_OUT);
    end
  endtask

  initial begin
    rst = 1; step = 0; start = 0; in_tvalid = 0; out_tready = 0;
    test_reset();
    test_full_frame();
    test_backpressure();
    test_step_toggle();
    test_mid_reset();
    test_random();
    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/gb_stream_ctrl.md
# gb_stream_ctrl

Sequencing controller for the Gaussian-blur stencil datapath. Tracks pixel coordinates of the incoming raster stream and drives the 8-row line-buffer ring (write row, column address). It also generates the shift strobe for the 9x9 stencil window and the compute-valid strobe for the blur function. It owns the input/output AXI-stream handshakes and a one-entry output register, so the datapath itself stays free of control logic.

## Interface
Parameters:
- IMG_W, 488, columns per row (x range 0..IMG_W-1, must fit 9 bits)
- IMG_H, 648, rows per frame (y range 0..IMG_H-1, must fit 10 bits)
- WIN, 9, stencil edge; interior starts at x,y >= WIN-1

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset; overrides step
- step  in  1  global advance enable; when 0 all state holds, in_tready=0
- start  in  1  begin a frame (sampled only in IDLE)
- in_tvalid  in  1  input pixel valid (arg_1 side)
- in_tready  out  1  input pixel accepted when in_tvalid&in_tready
- lb_wr_en  out  1  write accepted pixel into line buffer this cycle
- lb_wr_row  out  3  ring row index (RAM_w)
- lb_addr  out  9  column address (RAM_x)
- row_idx  out  10  current row (RAM_y)
- win_shift  out  1  shift stencil window one column this cycle
- out_load  out  1  capture blur result into output register this cycle
- out_tvalid  out  1  output pixel valid (arg_0 side)
- out_tready  in  1  downstream ready
- out_border  out  1  output is border pass-through (only with GB_CTRL_BORDER_EN, else tied 0)
- busy  out  1  state != IDLE
- frame_done  out  1  one-cycle pulse on frame completion

## Operation
- States: IDLE, RUN, FLUSH, DONE.
- IDLE: counters x=0, y=0, w=0; start&step -> RUN.
- RUN: in_tready = step & (~out_tvalid | out_tready). On accept (acc):
  - lb_wr_en=1, win_shift=1, addresses = current x/w/y.
  - x++; at x==IDLE_W-1: x<=0, y++, w<=w+1 (3-bit natural wrap 7->0).
  - out_load = acc & (x>=WIN-1) & (y>=WIN-1).
  - acc at x==IMG_W-1, y==IMG_H-1 -> FLUSH.
- Output register: out_load sets out_tvalid next cycle. out_tvalid&out_tready without out_load clears it. Both in the same cycle keep it set with the new data. Never dropped, never duplicated.
- FLUSH: in_tready=0; when out_tvalid==0 (or cleared this cycle) -> DONE.
- DONE: frame_done=1 for one cycle -> IDLE.
- lb_wr_en, win_shift, out_load are combinational from acc and are 0 whenever step=0.
- start outside IDLE ignored; in_tvalid in IDLE/FLUSH/DONE ignored (tready=0).

## Timing
- Reset values: state=IDLE, x=0, y=0, w=0, in_tready=0, lb_wr_en=0, win_shift=0, out_load=0, out_tvalid=0, out_border=0, busy=0, frame_done=0.
- Input-to-output latency: pixel accepted in cycle t -> out_tvalid in t+1 (if interior).
- Sustained throughput 1 pixel/cycle with out_tready=1; out_tready low stalls input in the same cycle via in_tready.
- Default frame: 316224 accepts, 307200 outputs (480x640 interior).
- Reset mid-frame: all state to reset values next edge, pending output discarded, no frame_done.
- step=0 mid-frame: freeze everything including out_tvalid (held high if set); resumes exactly.

## Configuration
- GB_CTRL_BORDER_EN defined: out_load on every accept; out_border=1 when x<WIN-1 or y<WIN-1 (datapath passes raw pixel); output count = IMG_W*IMG_H.
- Undefined: interior only, out_border constant 0, count (IMG_W-WIN+1)*(IMG_H-WIN+1).

## Test plan
- Reset then idle: rst 3 cycles, in_tvalid=1 -> in_tready=0, out_tvalid=0, all reset values hold.
- Full frame, out_tready=1, in_tvalid=1: exactly 316224 accepts, 307200 out_tvalid beats, first beat the cycle after accept at x=8,y=8, frame_done once after last.
- Ring wrap: after row 7 ends lb_wr_row=0 for row 8; lb_addr wraps 487->0 with row_idx increment.
- Backpressure: out_tready=0 for 5 cycles with out_tvalid=1 -> in_tready=0, counters frozen, no lost or duplicated beat.
- step toggling 1/0 every cycle -> identical output sequence to the step=1 run, at half rate.
- rst asserted at x=100,y=20 -> next cycle IDLE, x=y=w=0, out_tvalid=0; new start runs a clean frame. With GB_CTRL_BORDER_EN: 316224 beats, first 8 rows flagged out_border=1.
